dffram_mem_bridge: RTL

//  Adapts the core's req/gnt/rvalid memory port (instruction or data side) to a

---
 rtl/dffram_mem_bridge_pkg.sv | 23 ++
 rtl/dffram_mem_bridge_if.sv | 26 ++
 rtl/dffram_mem_bridge_resp_delay.sv | 122 ++++++++++++
 rtl/dffram_mem_bridge.sv | 58 +++++
 4 files changed

// File: rtl/dffram_mem_bridge_pkg.sv
// Shared types and constants for the core-to-DFFRAM memory bridge.
package dffram_mem_bridge_pkg;

    // Response sequencer states; only used when extra wait states are configured.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bridge_state_e;

    // Wide enough for wait-state counts of 0..7.
    localparam int WaitCntW = 3;

    // Default byte base address of the RAM window.
    localparam logic [31:0] DefaultBaseAddr = 32'h2000_0000;

    // A byte mask reaches the macro only for an accepted, enabled write.
    function automatic logic [3:0] write_mask(input logic en, input logic we,
                                              input logic [3:0] be);
        return (en && we) ? be : 4'h0;
    endfunction

endpackage

// File: rtl/dffram_mem_bridge_if.sv
// Core-side req/gnt/rvalid memory port, shared by the bridge and its requester.
interface dffram_mem_bridge_if;

    logic        req;
    logic        gnt;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    // The core drives requests and consumes grant and response.
    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    // The bridge accepts requests and produces grant and response.
    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/dffram_mem_bridge_resp_delay.sv
// Turns an issue pulse into a one-cycle response pulse WaitStates+1 cycles later,
// holding the error flag and the read data that goes with it.
module dffram_mem_bridge_resp_delay
    import dffram_mem_bridge_pkg::*;
#(
    parameter int WaitStates = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        issue_i,
    input  logic        issue_err_i,
    input  logic        issue_rd_i,
    input  logic [31:0] ram_do_i,
    output logic        busy_o,
    output logic        rvalid_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);

    if (WaitStates == 0) begin : g_no_wait

        logic rvalid_q, rvalid_d;
        logic err_q, err_d;
        logic rd_q, rd_d;

        // Remember what was issued this cycle; its response goes out next cycle.
        always_comb begin
            rvalid_d = issue_i;
            err_d    = issue_i & issue_err_i;
            rd_d     = issue_i & issue_rd_i;
        end

        // Response flags; a reset drops anything pending.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid_q <= 1'b0;
                err_q    <= 1'b0;
                rd_q     <= 1'b0;
            end else begin
                rvalid_q <= rvalid_d;
                err_q    <= err_d;
                rd_q     <= rd_d;
            end
        end

        // The macro output is already valid in the response cycle, so pass it straight through.
        always_comb begin
            busy_o   = 1'b0;
            rvalid_o = rvalid_q;
            err_o    = err_q;
            rdata_o  = (rvalid_q && rd_q) ? ram_do_i : 32'h0;
        end

    end else begin : g_wait

        localparam logic [WaitCntW-1:0] CntLoad = WaitCntW'(WaitStates);

        bridge_state_e         state_q, state_d;
        logic [WaitCntW-1:0]   cnt_q, cnt_d;
        logic                  err_q, err_d;
        logic                  rd_q, rd_d;
        logic [31:0]           rdata_q, rdata_d;

        // Sequencer: load the counter on issue, capture Do on the first wait cycle, respond when it runs out.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            err_d   = err_q;
            rd_d    = rd_q;
            rdata_d = rdata_q;
            case (state_q)
                IDLE, RESP: begin
                    if (issue_i) begin
                        state_d = WAIT;
                        cnt_d   = CntLoad;
                        err_d   = issue_err_i;
                        rd_d    = issue_rd_i;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q == CntLoad) begin
                        rdata_d = rd_q ? ram_do_i : 32'h0;
                    end
                    cnt_d = cnt_q - WaitCntW'(1);
                    if (cnt_q == WaitCntW'(1)) begin
                        state_d = RESP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Sequencer registers; a reset abandons the pending response.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                err_q   <= 1'b0;
                rd_q    <= 1'b0;
                rdata_q <= 32'h0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                err_q   <= err_d;
                rd_q    <= rd_d;
                rdata_q <= rdata_d;
            end
        end

        // Response outputs are only non-zero in the response cycle.
        always_comb begin
            busy_o   = (state_q == WAIT);
            rvalid_o = (state_q == RESP);
            err_o    = (state_q == RESP) && err_q;
            rdata_o  = (state_q == RESP) ? rdata_q : 32'h0;
        end

    end

endmodule

// File: rtl/dffram_mem_bridge.sv
// Bridges the core req/gnt/rvalid memory port onto a single-port DFFRAM macro.
module dffram_mem_bridge
    import dffram_mem_bridge_pkg::*;
#(
    parameter logic [31:0] BaseAddr   = DefaultBaseAddr,
    parameter int          RamAw      = 10,
    parameter int          WaitStates = 0,
    parameter bit          ReadOnly   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    dffram_mem_bridge_if.slave bus,
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [RamAw-1:0]  ram_a_o,
    output logic [31:0]       ram_di_o,
    input  logic [31:0]       ram_do_i
);

    localparam logic [31:0] WindowBytes = 32'd4 << RamAw;

    logic [31:0] offs;
    logic        hit;
    logic        bad;
    logic        busy;
    logic        issue;
    logic        issue_rd;

    // Decode the window (wrapping subtraction, so addresses below the base miss) and drive the macro in the grant cycle.
    always_comb begin
        offs     = bus.addr - BaseAddr;
        hit      = (offs < WindowBytes);
        bad      = !hit || (bus.we && ReadOnly) || (bus.we && (bus.be == 4'h0));
        issue    = bus.req && !busy;
        issue_rd = issue && !bad && !bus.we;
        bus.gnt  = issue;
        ram_en_o = issue && !bad;
        ram_we_o = write_mask(issue && !bad, bus.we, bus.be);
        ram_a_o  = offs[RamAw+1:2];
        ram_di_o = bus.wdata;
    end

    dffram_mem_bridge_resp_delay #(
        .WaitStates (WaitStates)
    ) u_resp_delay (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .issue_i     (issue),
        .issue_err_i (bad),
        .issue_rd_i  (issue_rd),
        .ram_do_i    (ram_do_i),
        .busy_o      (busy),
        .rvalid_o    (bus.rvalid),
        .err_o       (bus.err),
        .rdata_o     (bus.rdata)
    );

endmodule
